// File: rtl/rv_muldiv_pkg.sv
// rv_muldiv_pkg: shared definitions for the RISC-V M-extension multiply/divide
// unit.
//   muldiv_op_t : operation codes MUL..REMU (encodings 0..7)
//   state_t     : sequencer states IDLE, CALC, FIX, DONE
//   helpers     : operand signedness and divide/remainder decode
package rv_muldiv_pkg;

   localparam int DEFAULT_DPWIDTH = 32;
   localparam int DEFAULT_CNTW    = $clog2(DEFAULT_DPWIDTH) + 1;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Divide-class operations share the restoring shift-subtract path.
   function automatic logic op_is_div(input muldiv_op_t op);
      return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
   endfunction

   function automatic logic op_is_rem(input muldiv_op_t op);
      return (op == REM) || (op == REMU);
   endfunction

   // rs1 is treated as two's complement for these operations.
   function automatic logic op_a_signed(input muldiv_op_t op);
      return (op == MUL) || (op == MULH) || (op == MULHSU) ||
             (op == DIV) || (op == REM);
   endfunction

   // rs2 is treated as two's complement for these operations.
   function automatic logic op_b_signed(input muldiv_op_t op);
      return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
   endfunction

endpackage

// File: rtl/rv_muldiv_if.sv
// rv_muldiv_if: request/response bundle between a requester and rv_muldiv.
//   start  : request strobe, only sampled while the unit is idle
//   op     : operation code (muldiv_op_t)
//   opa    : operand A (rs1), opb : operand B (rs2)
//   kill   : abort of the in-flight operation
//   busy   : unit is computing
//   done   : one-cycle pulse, result valid
//   result : result, stable from done until the next accepted start
//
// Handshake: a request is accepted on a rising edge where start=1, kill=0 and
// the unit is idle; starts at any other time are dropped, not queued. Each
// accepted request is answered by exactly one done pulse unless it is killed
// or reset first. The requester may hold start high; it is only seen in idle.
interface rv_muldiv_if #(
   parameter int DPWIDTH = 32
) ();

   rv_muldiv_pkg::muldiv_op_t op;
   logic                      start;
   logic                      kill;
   logic [DPWIDTH-1:0]        opa;
   logic [DPWIDTH-1:0]        opb;
   logic                      busy;
   logic                      done;
   logic [DPWIDTH-1:0]        result;

   modport master (
      output start, op, opa, opb, kill,
      input  busy, done, result
   );

   modport slave (
      input  start, op, opa, opb, kill,
      output busy, done, result
   );

endinterface

// File: rtl/rv_muldiv.sv
// rv_muldiv: iterative radix-2 multiply/divide unit for the RISC-V M extension.
// Multiplies by shift-add and divides by restoring shift-subtract, one bit per
// cycle, on sign-magnitude operands; the sign is applied in a single fix-up
// cycle afterwards. Divide by zero and signed overflow skip the iteration.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : rv_muldiv_if slave (start/op/opa/opb/kill in, busy/done/result out)
//   state_dbg : current sequencer state
module rv_muldiv
   import rv_muldiv_pkg::*;
#(
   parameter int DPWIDTH = DEFAULT_DPWIDTH,
   parameter int CNTW    = $clog2(DPWIDTH) + 1
) (
   input  logic       clk,
   input  logic       rst,
   rv_muldiv_if.slave bus,
   output state_t     state_dbg
);

   localparam int W = DPWIDTH;
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   state_t          state, state_nxt;
   logic [CNTW-1:0] cnt;
   muldiv_op_t      op_q;
   logic [W-1:0]    hi;        // product high half / partial remainder
   logic [W-1:0]    lo;        // multiplier then product low half / dividend then quotient
   logic [W-1:0]    b_mag;     // magnitude of operand B
   logic            neg_main;  // negate product or quotient in FIX
   logic            neg_rem;   // negate remainder in FIX
   logic [W-1:0]    result_q;

   // ---------------------------------------------------------------------
   // Request decode (only meaningful in IDLE)
   // ---------------------------------------------------------------------
   logic         accept;
   logic         div_zero;
   logic         div_ovf;
   logic         a_neg, b_neg;
   logic [W-1:0] a_mag_in, b_mag_in;
   logic [W-1:0] special_res;

   assign accept   = (state == IDLE) && bus.start && !bus.kill;
   assign div_zero = op_is_div(bus.op) && (bus.opb == '0);
   assign div_ovf  = ((bus.op == DIV) || (bus.op == REM)) &&
                     (bus.opa == MOST_NEG) && (bus.opb == '1);

   assign a_neg    = op_a_signed(bus.op) && bus.opa[W-1];
   assign b_neg    = op_b_signed(bus.op) && bus.opb[W-1];
   // The most negative value maps onto itself, which is its correct unsigned magnitude.
   assign a_mag_in = a_neg ? (~bus.opa + W'(1)) : bus.opa;
   assign b_mag_in = b_neg ? (~bus.opb + W'(1)) : bus.opb;

   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = op_is_rem(bus.op) ? bus.opa : '1;
      else if (div_ovf)
         special_res = op_is_rem(bus.op) ? '0 : bus.opa;
   end

   // ---------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------
   logic last_step;
   assign last_step = (cnt == CNTW'(W - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept)
               state_nxt = (div_zero || div_ovf) ? DONE : CALC;
         end
         CALC: begin
            if (bus.kill)       state_nxt = IDLE;
            else if (last_step) state_nxt = FIX;
         end
         FIX: begin
            if (bus.kill) state_nxt = IDLE;
            else          state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Shared W+1-bit adder/subtractor with carry out.
   // Multiply: hi + (lo[0] ? b : 0). Divide: {hi, next dividend bit} - b,
   // where a carry out means no borrow, i.e. the trial subtraction fits.
   // ---------------------------------------------------------------------
   logic [W:0]   add_x, add_y, add_y_eff;
   logic         add_sub;
   logic [W+1:0] add_out;
   logic         div_fits;

   always_comb begin
      add_sub = 1'b0;
      add_x   = {1'b0, hi};
      add_y   = '0;
      if (op_is_div(op_q)) begin
         add_sub = 1'b1;
         add_x   = {hi, lo[W-1]};
         add_y   = {1'b0, b_mag};
      end else if (lo[0]) begin
         add_y   = {1'b0, b_mag};
      end
   end

   assign add_y_eff = add_sub ? ~add_y : add_y;
   assign add_out   = {1'b0, add_x} + {1'b0, add_y_eff} + {{(W+1){1'b0}}, add_sub};
   assign div_fits  = add_out[W+1];

   // ---------------------------------------------------------------------
   // Sign fix-up and result selection
   // ---------------------------------------------------------------------
   logic [2*W-1:0] prod, prod_fix;
   logic [W-1:0]   quo_fix, rem_fix, fix_res;

   assign prod     = {hi, lo};
   assign prod_fix = neg_main ? (~prod + (2*W)'(1)) : prod;
   assign quo_fix  = neg_main ? (~lo + W'(1)) : lo;
   assign rem_fix  = neg_rem  ? (~hi + W'(1)) : hi;

   always_comb begin
      fix_res = '0;
      unique case (op_q)
         MUL:                  fix_res = prod_fix[W-1:0];
         MULH, MULHSU, MULHU:  fix_res = prod_fix[2*W-1:W];
         DIV, DIVU:            fix_res = quo_fix;
         REM, REMU:            fix_res = rem_fix;
         default:              fix_res = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         op_q     <= MUL;
         hi       <= '0;
         lo       <= '0;
         b_mag    <= '0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         result_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  op_q     <= bus.op;
                  hi       <= '0;
                  lo       <= a_mag_in;
                  b_mag    <= b_mag_in;
                  neg_main <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  cnt      <= '0;
                  if (div_zero || div_ovf)
                     result_q <= special_res;
               end
            end
            CALC: begin
               if (!bus.kill) begin
                  cnt <= cnt + CNTW'(1);
                  if (op_is_div(op_q)) begin
                     hi <= div_fits ? add_out[W-1:0] : add_x[W-1:0];
                     lo <= {lo[W-2:0], div_fits};
                  end else begin
                     // Shift the W+1-bit sum right into {hi, lo}.
                     hi <= add_out[W:1];
                     lo <= {add_out[0], lo[W-1:1]};
                  end
               end
            end
            FIX: begin
               if (!bus.kill)
                  result_q <= fix_res;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy   = (state == CALC) || (state == FIX);
   assign bus.done   = (state == DONE);
   assign bus.result = result_q;
   assign state_dbg  = state;

endmodule

// File: tb/tb_rv_muldiv.sv
// tb_rv_muldiv: directed bench for rv_muldiv at DPWIDTH=32. Expected results
// are hand-computed constants queued in exp_q when an operation is issued.
module tb_rv_muldiv;
   import rv_muldiv_pkg::*;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic   clk;
   logic   rst;
   state_t state_dbg;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   rv_muldiv_if #(.DPWIDTH(W)) bus ();

   rv_muldiv #(.DPWIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks (called just after a falling edge) ----------------
   task automatic issue(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.opa   = a;
      bus.opb   = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // cyc0 is the number of cycles already elapsed since the start edge.
   task automatic wait_done(input string tag, input int cyc0, output int cyc);
      cyc = cyc0;
      while (bus.done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " done seen"}, W'(bus.done), W'(1));
   endtask

   task automatic run_op(input string tag, input muldiv_op_t op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input int exp_lat);
      int           cyc;
      logic [W-1:0] exp;
      exp_q.push_back(exp_res);
      issue(op, a, b);
      wait_done(tag, 1, cyc);
      exp = exp_q.pop_front();
      check({tag, " latency"}, W'(cyc), W'(exp_lat));
      check({tag, " result"}, bus.result, exp);
      @(negedge clk);
      check({tag, " done pulse"}, W'(bus.done), W'(0));
      check({tag, " result held"}, bus.result, exp);
   endtask

   // ---------------- global time limit ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int           cyc;
      int           seen;
      logic [W-1:0] exp;

      rst       = 1'b0;
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      bus.op    = MUL;
      bus.opa   = '0;
      bus.opb   = '0;
      repeat (2) @(negedge clk);

      check("reset busy",   W'(bus.busy), W'(0));
      check("reset done",   W'(bus.done), W'(0));
      check("reset result", bus.result,   W'(0));
      check("reset state",  W'(state_dbg), W'(0));

      // First start lands on the first rising edge with reset released.
      rst = 1'b1;
      run_op("mul 7*-3",       MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      // Back-to-back: starts in the idle cycle right after done.
      run_op("mulhu max*max",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      run_op("mulh -1*-1",     MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
      run_op("mulhsu -1*max",  MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      run_op("mul shift",      MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34);
      run_op("div -7/2",       DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
      run_op("rem -7%2",       REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
      run_op("div 7/-2",       DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
      run_op("rem 7%-2",       REM,    32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 34);
      run_op("divu 100/7",     DIVU,   32'd100,      32'd7,         32'd14,        34);
      run_op("remu 100%7",     REMU,   32'd100,      32'd7,         32'd2,         34);
      run_op("divu big/max",   DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
      run_op("remu big/max",   REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);

      // Divide by zero and signed overflow short-cut straight to DONE.
      run_op("divu by 0",      DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1);
      run_op("remu by 0",      REMU,   32'h0000_1234, 32'd0,         32'h0000_1234, 1);
      run_op("div by 0",       DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);
      run_op("div ovf",        DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem ovf",        REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

      // Start while busy is dropped: the original DIVU finishes on time.
      exp_q.push_back(32'd14);
      issue(DIVU, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      issue(MUL, 32'd2, 32'd3);
      wait_done("busy start", 5, cyc);
      exp = exp_q.pop_front();
      check("busy start latency", W'(cyc), W'(34));
      check("busy start result", bus.result, exp);

      // Start during the DONE cycle is dropped as well.
      issue(MUL, 32'd2, 32'd3);
      check("done-cycle start busy",  W'(bus.busy), W'(0));
      check("done-cycle start state", W'(state_dbg), W'(IDLE));
      check("done-cycle start result", bus.result, 32'd14);

      // Kill 10 cycles into a DIVU.
      issue(DIVU, 32'd1000, 32'd10);
      repeat (9) @(negedge clk);
      check("pre-kill busy", W'(bus.busy), W'(1));
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      check("kill busy",   W'(bus.busy), W'(0));
      check("kill done",   W'(bus.done), W'(0));
      check("kill result", bus.result,   32'd14);
      run_op("after kill", DIVU, 32'd1000, 32'd10, 32'd100, 34);

      // Kill beats start in the same idle cycle.
      bus.kill = 1'b1;
      issue(MUL, 32'd5, 32'd5);
      bus.kill = 1'b0;
      check("kill+start busy",  W'(bus.busy), W'(0));
      check("kill+start state", W'(state_dbg), W'(IDLE));
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen++;
      end
      check("kill+start no done", W'(seen), W'(0));
      check("kill+start result", bus.result, 32'd100);

      // Reset in the middle of a MUL aborts at once, with no done afterwards.
      issue(MUL, 32'd5, 32'd6);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid rst busy",   W'(bus.busy), W'(0));
      check("mid rst done",   W'(bus.done), W'(0));
      check("mid rst result", bus.result,   W'(0));
      check("mid rst state",  W'(state_dbg), W'(IDLE));
      @(negedge clk);
      rst  = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen++;
      end
      check("mid rst no done", W'(seen), W'(0));
      run_op("after rst", MUL, 32'd5, 32'd6, 32'd30, 34);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv_muldiv.md
RV_MULDIV -- requirements
Module: rv_muldiv

Interface
REQ-001 Parameter DPWIDTH, default 32, sets operand and result width in bits; legal values are even and at least 8.
REQ-002 Parameter CNTW, default $clog2(DPWIDTH)+1, sets the iteration counter width.
REQ-003 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request strobe, sampled only in IDLE.
REQ-006 op  input  3  operation code: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (encodings 0..7).
REQ-007 opa  input  DPWIDTH  operand A (rs1), sampled with start.
REQ-008 opb  input  DPWIDTH  operand B (rs2), sampled with start.
REQ-009 kill  input  1  abort of the in-flight operation.
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse marking a valid result.
REQ-012 result  output  DPWIDTH  final result, held stable from done until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX and DONE.
REQ-014 A start in IDLE SHALL latch op, opa and opb.
REQ-015 After latching, the block SHALL go to CALC, except in the special cases of REQ-022 and REQ-023, where it SHALL go directly to DONE.
REQ-016 CALC SHALL last exactly DPWIDTH cycles, counted by an up-counter that is cleared on entry.
REQ-017 Each CALC cycle SHALL perform one radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 Before CALC, signed operands SHALL be converted to magnitudes.
  - Operand A is signed for MUL, MULH, MULHSU, DIV and REM.
  - Operand B is signed for MUL, MULH, DIV and REM.
REQ-019 FIX SHALL last one cycle and SHALL conditionally negate the magnitude result.
  - Multiply negates the 2*DPWIDTH product when sign(A) XOR sign(B) (sign(A) only for MULHSU).
  - Quotient negates when sign(A) XOR sign(B).
  - Remainder negates when sign(A).
REQ-020 Result selection SHALL be:
  - MUL returns the low DPWIDTH product bits.
  - MULH, MULHSU and MULHU return the high DPWIDTH product bits.
  - DIV and DIVU return the quotient.
  - REM and REMU return the remainder.
REQ-021 done SHALL be high for exactly one cycle, in DONE, after which the FSM SHALL return to IDLE; normal latency from the start edge to done is DPWIDTH+2 cycles.
REQ-022 Divide by zero SHALL complete with done 1 cycle after start.
  - Quotient is all ones.
  - Remainder equals opa.
REQ-023 Signed overflow (opa = most-negative, opb = all ones, DIV/REM) SHALL complete with done 1 cycle after start.
  - Quotient equals opa.
  - Remainder is 0.
REQ-024 start while busy SHALL be ignored, and start in the DONE cycle SHALL be ignored.
REQ-025 start in IDLE on the cycle immediately after done SHALL be accepted.
REQ-026 kill while busy SHALL return the FSM to IDLE on the next edge, with no done pulse and result unchanged.
REQ-027 kill in IDLE SHALL have no effect, and kill takes priority over start in the same cycle.
REQ-028 Arithmetic SHALL be unsigned on explicit DPWIDTH+1-bit intermediates; product and remainder registers are sized exactly and carries are never truncated silently.

Reset
REQ-029 While rst is low, state SHALL be IDLE; busy, done, result, the counter and all operand registers SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL abort immediately, with no done pulse after release.
REQ-031 The first start SHALL be accepted on the first rising edge with rst high.

Structure
REQ-032 The op encodings (muldiv_op_t enum) and the FSM state enum SHALL live in the shared package rv_muldiv_pkg, alongside the existing datapath params.
REQ-033 The block SHALL be a single module with no sub-module; the shift-add and shift-subtract steps share one DPWIDTH+1-bit adder/subtractor.

Verification (DPWIDTH=32)
REQ-034 MUL opa=7, opb=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 cycles after start.
REQ-035 MULHU opa=opb=0xFFFFFFFF -> result 0xFFFFFFFE; MULH on the same operands -> result 0x00000000.
REQ-036 DIV opa=0xFFFFFFF9 (-7), opb=2 -> result 0xFFFFFFFD; REM on the same operands -> result 0xFFFFFFFF.
REQ-037 DIVU opa=0x1234, opb=0 -> result 0xFFFFFFFF, done 1 cycle after start; DIV opa=0x80000000, opb=0xFFFFFFFF -> result 0x80000000; REM on the same operands -> result 0.
REQ-038 Abort and back-to-back cases:
  - kill pulsed 10 cycles into DIVU -> no done, busy low next cycle, result unchanged.
  - New start in the following cycle -> completes normally.
  - rst low mid-MUL -> all outputs 0 immediately.
